// File: rtl/noc_pkg.sv
// Shared defaults and helpers for the NoC virtual-channel input buffer.
// The address field always sits in the top bits of a flit.
package noc_pkg;

   localparam int NOC_DATA_WIDTH   = 16;
   localparam int NOC_ADDRESS_SIZE = 4;
   localparam int NOC_DEPTH        = 8;
   localparam int NOC_NUM_VC       = 2;

   // Widest flit the extraction helper handles; callers truncate the result.
   localparam int FLIT_MAX_WIDTH   = 64;

   function automatic logic [FLIT_MAX_WIDTH-1:0] flit_address(
      input logic [FLIT_MAX_WIDTH-1:0] flit,
      input int                        data_width,
      input int                        address_size
   );
      logic [FLIT_MAX_WIDTH-1:0] mask;
      mask = (FLIT_MAX_WIDTH'(1) << address_size) - FLIT_MAX_WIDTH'(1);
      return (flit >> (data_width - address_size)) & mask;
   endfunction

endpackage

// File: rtl/noc_fifo_bank.sv
// Single virtual-channel circular buffer with occupancy count.
// The head flit is shown combinationally and reads as zero while empty.
module noc_fifo_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int CW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count       = count_q;
   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= CW'(AF_THRESH));
   assign head_data   = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC input buffer: VC decode, head-flit mux and sticky error flags
// around one noc_fifo_bank per virtual channel.
module noc_vc_fifo
   import noc_pkg::*;
#(
   parameter  int DATA_WIDTH   = NOC_DATA_WIDTH,
   parameter  int ADDRESS_SIZE = NOC_ADDRESS_SIZE,
   parameter  int DEPTH        = NOC_DEPTH,
   parameter  int NUM_VC       = NOC_NUM_VC,
   parameter  int AF_THRESH    = DEPTH - 2,
   localparam int VCW          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int CW           = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [VCW-1:0]          wr_vc,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   input  logic [VCW-1:0]          rd_vc,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [ADDRESS_SIZE-1:0] pkt_address,
   output logic [NUM_VC-1:0]       full,
   output logic [NUM_VC-1:0]       empty,
   output logic [NUM_VC-1:0]       almost_full,
   output logic [NUM_VC*CW-1:0]    count,
   output logic                    overflow,
   output logic                    underflow
);

   logic [NUM_VC-1:0]     push;
   logic [NUM_VC-1:0]     pop;
   logic [DATA_WIDTH-1:0] head [NUM_VC];
   logic                  wr_vc_ok;
   logic                  rd_vc_ok;
   logic                  wr_full_sel;
   logic                  rd_empty_sel;
   logic [DATA_WIDTH-1:0] rd_sel;
   logic                  rd_accept;
   logic                  wr_accept;
   logic                  overflow_q;
   logic                  underflow_q;

   assign wr_vc_ok = ({1'b0, wr_vc} < (VCW + 1)'(NUM_VC));
   assign rd_vc_ok = ({1'b0, rd_vc} < (VCW + 1)'(NUM_VC));

   // An out-of-range VC selects nothing: it looks empty to a read.
   always_comb begin
      wr_full_sel  = 1'b0;
      rd_empty_sel = 1'b1;
      rd_sel       = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (wr_vc == VCW'(i)) begin
            wr_full_sel = full[i];
         end
         if (rd_vc == VCW'(i)) begin
            rd_empty_sel = empty[i];
            rd_sel       = head[i];
         end
      end
   end

   // A full VC still takes a write when the same cycle pops it.
   assign rd_accept = rd_en && rd_vc_ok && !rd_empty_sel;
   assign wr_accept = wr_en && wr_vc_ok &&
                      (!wr_full_sel || (rd_accept && (rd_vc == wr_vc)));

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      assign push[g] = wr_accept && (wr_vc == VCW'(g));
      assign pop[g]  = rd_accept && (rd_vc == VCW'(g));

      noc_fifo_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .AF_THRESH  (AF_THRESH),
         .CW         (CW)
      ) u_bank (
         .clk         (clk),
         .rst_n       (rst_n),
         .push        (push[g]),
         .pop         (pop[g]),
         .wr_data     (wr_data),
         .head_data   (head[g]),
         .full        (full[g]),
         .empty       (empty[g]),
         .almost_full (almost_full[g]),
         .count       (count[g*CW +: CW])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en && !wr_accept) begin
            overflow_q <= 1'b1;
         end
         if (rd_en && !rd_accept) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign rd_data     = rd_sel;
   assign pkt_address = ADDRESS_SIZE'(flit_address(FLIT_MAX_WIDTH'(rd_data),
                                                   DATA_WIDTH, ADDRESS_SIZE));
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Self-checking bench for noc_vc_fifo: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_noc_vc_fifo;

   localparam int DW     = 16;
   localparam int AW     = 4;
   localparam int DEPTH  = 8;
   localparam int NUM_VC = 2;
   localparam int AF     = DEPTH - 2;
   localparam int VCW    = 1;
   localparam int CW     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [VCW-1:0]    wr_vc;
   logic [DW-1:0]     wr_data;
   logic              rd_en;
   logic [VCW-1:0]    rd_vc;
   logic [DW-1:0]     rd_data;
   logic [AW-1:0]     pkt_address;
   logic [NUM_VC-1:0] full;
   logic [NUM_VC-1:0] empty;
   logic [NUM_VC-1:0] almost_full;
   logic [NUM_VC*CW-1:0] count;
   logic              overflow;
   logic              underflow;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] mq [NUM_VC][$];
   logic          m_ovf;
   logic          m_unf;
   bit            model_valid = 1'b0;
   int            pops [NUM_VC];

   typedef struct {
      logic          rst;
      logic          we;
      int            wvc;
      logic [DW-1:0] wd;
      logic          re;
      int            rvc;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      logic [1:0]    fl;
      logic [1:0]    em;
      logic [1:0]    af;
      logic [DW-1:0] rd;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t vecs[$];

   noc_vc_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_vc       (wr_vc),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_vc       (rd_vc),
      .rd_data     (rd_data),
      .pkt_address (pkt_address),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic we, int wvc, logic [DW-1:0] wd, logic re, int rvc,
                               logic [CW-1:0] c0, logic [CW-1:0] c1, logic [1:0] fl,
                               logic [1:0] em, logic [1:0] af, logic [DW-1:0] rd,
                               logic ovf, logic unf);
      vec_t v;
      v.rst = 1'b1; v.we = we; v.wvc = wvc; v.wd = wd; v.re = re; v.rvc = rvc;
      v.c0 = c0; v.c1 = c1; v.fl = fl; v.em = em; v.af = af; v.rd = rd;
      v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_head(input int vc);
      if (vc < NUM_VC && mq[vc].size() > 0) return mq[vc][0];
      return '0;
   endfunction

   // Compare every output against the reference model's view of this cycle.
   task automatic checkOutput(input string tag);
      logic [NUM_VC*CW-1:0] e_cnt;
      logic [NUM_VC-1:0]    e_full, e_empty, e_af;
      logic [DW-1:0]        e_rd;
      for (int v = 0; v < NUM_VC; v++) begin
         e_cnt[v*CW +: CW] = CW'(mq[v].size());
         e_full[v]  = (mq[v].size() == DEPTH);
         e_empty[v] = (mq[v].size() == 0);
         e_af[v]    = (mq[v].size() >= AF);
      end
      e_rd = model_head(int'(rd_vc));
      check({tag, " count"},       32'(count),       32'(e_cnt));
      check({tag, " full"},        32'(full),        32'(e_full));
      check({tag, " empty"},       32'(empty),       32'(e_empty));
      check({tag, " almost_full"}, 32'(almost_full), 32'(e_af));
      check({tag, " rd_data"},     32'(rd_data),     32'(e_rd));
      check({tag, " pkt_address"}, 32'(pkt_address), 32'(e_rd / 16'h1000));
      check({tag, " overflow"},    32'(overflow),    32'(m_ovf));
      check({tag, " underflow"},   32'(underflow),   32'(m_unf));
   endtask

   task automatic applyStimulus(input logic r, input logic we, input int wv,
                                input logic [DW-1:0] wd, input logic re, input int rv);
      rst_n   = r;
      wr_en   = we;
      wr_vc   = VCW'(wv);
      wr_data = wd;
      rd_en   = re;
      rd_vc   = VCW'(rv);
      @(negedge clk);
   endtask

   // Advance the model by one clock edge using the inputs now being driven.
   task automatic stepEdge();
      bit rd_ok, wr_ok;
      int wv, rv;
      @(posedge clk);
      wv = int'(wr_vc);
      rv = int'(rd_vc);
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) mq[v].delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         model_valid = 1'b1;
      end else begin
         rd_ok = rd_en && (rv < NUM_VC) && (mq[rv].size() > 0);
         wr_ok = wr_en && (wv < NUM_VC) &&
                 ((mq[wv].size() < DEPTH) || (rd_ok && rv == wv));
         if (rd_ok) begin
            void'(mq[rv].pop_front());
            pops[rv]++;
         end
         if (wr_ok) mq[wv].push_back(wr_data);
         if (wr_en && !wr_ok) m_ovf = 1'b1;
         if (rd_en && !rd_ok) m_unf = 1'b1;
      end
      #1;
   endtask

   task automatic cycle(input logic r, input logic we, input int wv,
                        input logic [DW-1:0] wd, input logic re, input int rv,
                        input string tag);
      applyStimulus(r, we, wv, wd, re, rv);
      if (model_valid) checkOutput(tag);
      stepEdge();
   endtask

   initial begin
      int n;
      string tag;
      pops[0] = 0;
      pops[1] = 0;

      // Scenario 1/2/5 table: expectations are what the outputs show during each row.
      for (int i = 0; i <= 8; i++) begin
         vecs.push_back(mk(1'b1, 0, 16'hA001 + 16'(i), 1'b0, 0,
                           CW'(i), '0, (i == 8) ? 2'b01 : 2'b00,
                           (i == 0) ? 2'b11 : 2'b10, (i >= AF) ? 2'b01 : 2'b00,
                           (i == 0) ? 16'h0000 : 16'hA001, 1'b0, 1'b0));
      end
      for (int j = 0; j < 8; j++) begin
         vecs.push_back(mk(1'b0, 0, '0, 1'b1, 0,
                           CW'(8 - j), '0, (j == 0) ? 2'b01 : 2'b00, 2'b10,
                           ((8 - j) >= AF) ? 2'b01 : 2'b00, 16'hA001 + 16'(j), 1'b1, 1'b0));
      end
      vecs.push_back(mk(1'b0, 0, '0, 1'b1, 1, '0, '0, 2'b00, 2'b11, 2'b00, 16'h0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 0, '0, 1'b0, 1, '0, '0, 2'b00, 2'b11, 2'b00, 16'h0, 1'b1, 1'b1));

      cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, "reset0");
      cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, "reset1");

      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0);
      check("reset count",       32'(count),       32'h0);
      check("reset empty",       32'(empty),       32'h3);
      check("reset full",        32'(full),        32'h0);
      check("reset almost_full", 32'(almost_full), 32'h0);
      check("reset flags",       32'({overflow, underflow}), 32'h0);
      stepEdge();

      foreach (vecs[k]) begin
         tag = $sformatf("vec%0d", k);
         applyStimulus(vecs[k].rst, vecs[k].we, vecs[k].wvc, vecs[k].wd, vecs[k].re, vecs[k].rvc);
         check({tag, " count"},       32'(count),       32'({vecs[k].c1, vecs[k].c0}));
         check({tag, " full"},        32'(full),        32'(vecs[k].fl));
         check({tag, " empty"},       32'(empty),       32'(vecs[k].em));
         check({tag, " almost_full"}, 32'(almost_full), 32'(vecs[k].af));
         check({tag, " rd_data"},     32'(rd_data),     32'(vecs[k].rd));
         check({tag, " pkt_address"}, 32'(pkt_address), 32'(vecs[k].rd >> 12));
         check({tag, " overflow"},    32'(overflow),    32'(vecs[k].ovf));
         check({tag, " underflow"},   32'(underflow),   32'(vecs[k].unf));
         checkOutput({tag, " model"});
         stepEdge();
      end

      // Scenario 3: a full VC accepts a write when popped in the same cycle.
      cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, "s3 reset");
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 0, 16'hC001 + 16'(i), 1'b0, 0, "s3 fill");
      cycle(1'b1, 1'b1, 0, 16'hB000, 1'b1, 0, "s3 rw");
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0);
      check("s3 count0 after rw", 32'(count[CW-1:0]), 32'd8);
      check("s3 no overflow", 32'(overflow), 32'h0);
      stepEdge();
      for (int j = 0; j < DEPTH; j++) begin
         applyStimulus(1'b1, 1'b0, 0, '0, 1'b1, 0);
         checkOutput("s3 drain");
         if (j == DEPTH - 2) check("s3 last old flit", 32'(rd_data), 32'h0000C008);
         if (j == DEPTH - 1) check("s3 bypass flit", 32'(rd_data), 32'h0000B000);
         stepEdge();
      end

      // Scenario 4: write VC1 while reading VC0.
      cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, "s4 reset");
      cycle(1'b1, 1'b1, 0, 16'h5555, 1'b0, 0, "s4 load");
      applyStimulus(1'b1, 1'b1, 1, 16'h3123, 1'b1, 0);
      check("s4 rd_data vc0", 32'(rd_data), 32'h5555);
      stepEdge();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 1);
      check("s4 rd_data vc1", 32'(rd_data), 32'h3123);
      check("s4 pkt_address", 32'(pkt_address), 32'h3);
      check("s4 counts", 32'(count), 32'h10);
      checkOutput("s4 model");
      stepEdge();

      // Scenario 5: drain VC1, then read it while empty.
      cycle(1'b1, 1'b0, 0, '0, 1'b1, 1, "s5 drain");
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b1, 1);
      check("s5 empty rd_data", 32'(rd_data), 32'h0);
      stepEdge();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 1);
      check("s5 underflow", 32'(underflow), 32'h1);
      check("s5 counts", 32'(count), 32'h0);
      stepEdge();

      // Scenario 6: reset wins over a concurrent write and clears the flags.
      cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, "s6 reset");
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0, 16'h7000 + 16'(i), 1'b0, 0, "s6 fill");
      cycle(1'b1, 1'b0, 0, '0, 1'b1, 1, "s6 underflow");
      cycle(1'b0, 1'b1, 0, 16'h7777, 1'b0, 0, "s6 reset+write");
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0);
      check("s6 count", 32'(count), 32'h0);
      check("s6 empty", 32'(empty), 32'h3);
      check("s6 flags", 32'({overflow, underflow}), 32'h0);
      check("s6 rd_data", 32'(rd_data), 32'h0);
      stepEdge();

      // Random traffic until each VC's read pointer has wrapped 20+ times.
      pops[0] = 0;
      pops[1] = 0;
      n = 0;
      while ((pops[0] < 21 * DEPTH || pops[1] < 21 * DEPTH) && n < 20000) begin
         cycle(1'b1, ($urandom_range(0, 99) < 50), int'($urandom_range(0, 1)),
               16'($urandom), ($urandom_range(0, 99) < 50), int'($urandom_range(0, 1)),
               "random");
         n++;
      end
      check("random wraps vc0 reached", 32'(pops[0] >= 21 * DEPTH), 32'h1);
      check("random wraps vc1 reached", 32'(pops[1] >= 21 * DEPTH), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/noc_vc_fifo.md
NOC_VC_FIFO -- requirements
Module: noc_vc_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 16, flit width in bits.
REQ-002 Parameter ADDRESS_SIZE, 4, destination-address field width; the field occupies the ADDRESS_SIZE MSBs of a flit.
REQ-003 Parameter DEPTH, 8, entries per virtual channel (VC); power of two, >=2.
REQ-004 Parameter NUM_VC, 2, number of independent VCs; >=1.
REQ-005 Parameter AF_THRESH, DEPTH-2, count at or above which almost_full asserts.
REQ-006 Derived constants: VCW = max(1, clog2(NUM_VC)) and CW = clog2(DEPTH)+1.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous and active-low.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_vc  in  VCW  target VC of the write.
REQ-011 wr_data  in  DATA_WIDTH  flit to write.
REQ-012 rd_en  in  1  read (pop) request.
REQ-013 rd_vc  in  VCW  VC being read/observed.
REQ-014 rd_data  out  DATA_WIDTH  head flit of VC rd_vc.
REQ-015 pkt_address  out  ADDRESS_SIZE  rd_data[DATA_WIDTH-1 -: ADDRESS_SIZE].
REQ-016 full  out  NUM_VC  per-VC full flags.
REQ-017 empty  out  NUM_VC  per-VC empty flags.
REQ-018 almost_full  out  NUM_VC  per-VC flag; high when count >= AF_THRESH.
REQ-019 count  out  NUM_VC*CW  per-VC occupancy, VC i at bits [i*CW +: CW].
REQ-020 overflow  out  1  sticky flag: a write was dropped.
REQ-021 underflow  out  1  sticky flag: a read was dropped.

Function
REQ-022 Each VC shall be an independent circular buffer with its own read pointer, write pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-023 Reads shall be first-word-fall-through: rd_data and pkt_address shall combinationally show the head of rd_vc, with zero read latency.
REQ-024 When empty[rd_vc]=1, rd_data and pkt_address shall be 0.
REQ-025 A write with full[wr_vc]=0 shall store wr_data at that VC's tail and increment its count at the next edge.
REQ-026 A write to a full VC shall be dropped and shall set overflow, unless a read pops that same VC in the same cycle; in that case the write shall be accepted and the count shall remain DEPTH.
REQ-027 A read with empty[rd_vc]=0 shall advance that VC's read pointer and decrement its count at the next edge.
REQ-028 A read on an empty VC shall be dropped and shall set underflow; there shall be no write-through bypass into an empty VC.
REQ-029 A simultaneous read and write on the same non-empty, non-full VC shall leave the count unchanged.
REQ-030 A simultaneous read and write on different VCs shall update each VC independently.
REQ-031 full[i], empty[i] and almost_full[i] shall be registered-state derived (count==DEPTH, count==0, count>=AF_THRESH) and valid in the same cycle the count is.
REQ-032 A wr_vc or rd_vc value >= NUM_VC shall make the operation a no-op, and the dropped write or read shall set overflow or underflow respectively.
REQ-033 overflow and underflow shall stay set until reset.

Reset
REQ-034 While rst_n=0 at a clock edge, all pointers and counts shall be cleared, along with overflow and underflow; the next cycle shall show empty=all-ones, full=0, almost_full=0 and count=0.
REQ-035 Reset shall take priority over concurrent wr_en or rd_en, and a reset mid-operation shall discard all stored flits.
REQ-036 Storage array contents need not be reset, and cleared data shall not be observable because of REQ-024.

Structure
REQ-037 Shared package noc_pkg shall hold the default DATA_WIDTH, ADDRESS_SIZE, DEPTH and NUM_VC values, plus the address-field extraction function.
REQ-038 One sub-module, noc_fifo_bank (a single-VC circular buffer with count), shall be instantiated NUM_VC times via generate.
REQ-039 The top level shall contain only VC decode, the rd_vc output mux and the sticky flags.

Verification (DATA_WIDTH=16, ADDRESS_SIZE=4, DEPTH=8, NUM_VC=2)
REQ-040 Scenario 1: reset, then write 0xA001..0xA008 to VC0 -> count0=8, full[0]=1, almost_full[0] high from count 6, VC1 stays empty, rd_data=0xA001, pkt_address=0xA.
REQ-041 Scenario 2: a 9th write to full VC0 -> dropped, overflow=1, count0=8; after 8 reads, data is 0xA001..0xA008 in order, then empty[0]=1.
REQ-042 Scenario 3: VC0 full, read VC0 and write 0xB000 to VC0 in the same cycle -> count0 stays 8, and 0xB000 emerges after 0xA008.
REQ-043 Scenario 4: write 0x3123 to VC1 and read VC0 concurrently (VC0 holding 0x5555) -> rd_data=0x5555, and after the edge count1=1 with rd_vc=1 giving rd_data=0x3123 and pkt_address=0x3.
REQ-044 Scenario 5: read an empty VC1 -> underflow=1, rd_data=0, counts unchanged.
REQ-045 Scenario 6: 3 flits in VC0, drive rst_n=0 for one edge with wr_en=1 -> count0=0, empty=2'b11, overflow=0, underflow=0.
REQ-046 Coverage: 20 pointer wraps per VC under random traffic, checked against a scoreboard.
